// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer engine:
// FSM state encoding, requantisation widths and int8 saturation limits.
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ACT,
    S_LOAD_PAR,
    S_MAC,
    S_REQ,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int ACC_W  = 32;
  localparam int PROD_W = 64;
  localparam int RQ_W   = 35;
  localparam int Y_W    = 8;

  localparam logic signed [Y_W-1:0]  Y_MIN   = -8'sd128;
  localparam logic signed [Y_W-1:0]  Y_MAX   = 8'sd127;
  localparam logic signed [RQ_W-1:0] Y_MIN_W = -35'sd128;
  localparam logic signed [RQ_W-1:0] Y_MAX_W = 35'sd127;

  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [RQ_W-1:0] v);
    if (v > Y_MAX_W)      return Y_MAX;
    else if (v < Y_MIN_W) return Y_MIN;
    else                  return v[Y_W-1:0];
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Three-stage requantiser: offset, fixed-point scale by an unsigned Q32
// multiplier with round-half-up, then zero point and int8 saturation.
module fc_requant
  import fc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ACC_W-1:0]         acc,
  input  logic [31:0]              m,
  input  logic [31:0]              sub,
  input  logic [31:0]              add,
  input  logic signed [31:0]       out_zp,
  output logic signed [Y_W-1:0]    y
);

  logic signed [31:0]     t_q;
  logic signed [PROD_W-1:0] p_q;
  logic signed [32:0]     m_s;
  logic signed [RQ_W-1:0] r_w;

  // M is unsigned, so it gets a zero sign bit before the signed multiply.
  assign m_s = {1'b0, m};
  assign r_w = 35'($signed(p_q[63:32])) + 35'({1'b0, p_q[31]}) + 35'(out_zp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      p_q <= '0;
      y   <= '0;
    end else begin
      t_q <= acc - sub + add;
      p_q <= 64'(t_q) * 64'(m_s);
      y   <= sat_y(r_w);
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected int8 layer: loads activations once, then per output neuron
// loads requant params, accumulates weights, requantises and writes the result.
// Define FC_ARGMAX_EN to add argmax tracking on class_idx/class_valid.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int          N_IN     = 8,
  parameter int          N_OUT    = 2,
  parameter int          RD_LAT   = 2,
  parameter logic [15:0] IN_BASE  = 16'h0000,
  parameter logic [15:0] W_BASE   = 16'd21960,
  parameter logic [8:0]  P_BASE   = 9'd168,
  parameter logic [15:0] OUT_BASE = 16'h8000,
  parameter int          OUT_ZP   = 41
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                ram_addr_r,
  output logic                       ram_en_r,
  input  logic signed [7:0]          ram_data_r,
  output logic [15:0]                rom_addr_w,
  output logic                       rom_en_w,
  input  logic signed [7:0]          rom_data_w,
  output logic [8:0]                 rom_addr_p,
  output logic                       rom_en_p,
  input  logic [31:0]                rom_data_p,
  output logic [15:0]                ram_addr_w,
  output logic signed [7:0]          ram_data_w,
  output logic                       ram_en,
  output logic                       ram_wea,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic                       class_valid
);

  localparam logic [15:0] N_IN16   = 16'(N_IN);
  localparam logic [15:0] LAT16    = 16'(RD_LAT);
  localparam logic [15:0] ACT_LAST = 16'(N_IN + RD_LAT - 1);
  localparam logic [15:0] PAR_LAST = 16'(3 + RD_LAT - 1);
  localparam logic [15:0] REQ_LAST = 16'd2;
  localparam logic [15:0] O_LAST   = 16'(N_OUT - 1);

  state_e             state, state_n;
  logic [15:0]        cnt, o_idx, act_iss, par_iss;
  logic signed [7:0]  act [N_IN];
  logic [ACC_W-1:0]   acc;
  logic [31:0]        m_q, sub_q, add_q;
  logic signed [7:0]  y;
  logic signed [15:0] prod;

  // Issue index clamps to the last address while trailing data is awaited.
  assign act_iss = (cnt < N_IN16) ? cnt : N_IN16 - 16'd1;
  assign par_iss = (cnt < 16'd3) ? cnt : 16'd2;
  assign prod    = 16'(act[0]) * 16'(rom_data_w);

  // Handshake: start is sampled only in IDLE; busy stays high from the
  // accepting edge through the single-cycle done pulse, then returns low.
  always_comb begin
    state_n    = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    ram_en_r   = 1'b0;
    ram_addr_r = '0;
    rom_en_w   = 1'b0;
    rom_addr_w = '0;
    rom_en_p   = 1'b0;
    rom_addr_p = '0;
    ram_en     = 1'b0;
    ram_wea    = 1'b0;
    ram_addr_w = '0;
    ram_data_w = '0;
    case (state)
      S_IDLE: if (start) state_n = S_LOAD_ACT;
      S_LOAD_ACT: begin
        ram_en_r   = 1'b1;
        ram_addr_r = IN_BASE + act_iss;
        if (cnt == ACT_LAST) state_n = S_LOAD_PAR;
      end
      S_LOAD_PAR: begin
        rom_en_p   = 1'b1;
        rom_addr_p = P_BASE + 9'(16'd3 * o_idx + par_iss);
        if (cnt == PAR_LAST) state_n = S_MAC;
      end
      S_MAC: begin
        rom_en_w   = 1'b1;
        rom_addr_w = W_BASE + o_idx * N_IN16 + act_iss;
        if (cnt == ACT_LAST) state_n = S_REQ;
      end
      S_REQ: if (cnt == REQ_LAST) state_n = S_WRITE;
      S_WRITE: begin
        ram_en     = 1'b1;
        ram_wea    = 1'b1;
        ram_addr_w = OUT_BASE + o_idx;
        ram_data_w = y;
        state_n    = (o_idx == O_LAST) ? S_DONE : S_LOAD_PAR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Activations live in a shift register: loaded by shifting in, then rotated
  // once per MAC pass so act[0] always holds the operand for the current weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      o_idx <= '0;
      acc   <= '0;
      m_q   <= '0;
      sub_q <= '0;
      add_q <= '0;
      for (int i = 0; i < N_IN; i++) act[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == S_IDLE) ? 16'd0 : cnt + 16'd1;
      case (state)
        S_IDLE: if (start) o_idx <= '0;
        S_LOAD_ACT: if (cnt >= LAT16) begin
          for (int i = 0; i < N_IN - 1; i++) act[i] <= act[i+1];
          act[N_IN-1] <= ram_data_r;
        end
        S_LOAD_PAR: begin
          acc <= '0;
          if (cnt >= LAT16) begin
            m_q   <= sub_q;
            sub_q <= add_q;
            add_q <= rom_data_p;
          end
        end
        S_MAC: if (cnt >= LAT16) begin
          acc <= acc + {{16{prod[15]}}, prod};
          for (int i = 0; i < N_IN - 1; i++) act[i] <= act[i+1];
          act[N_IN-1] <= act[0];
        end
        S_WRITE: o_idx <= o_idx + 16'd1;
        default: ;
      endcase
    end
  end

  fc_requant u_requant (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc    (acc),
    .m      (m_q),
    .sub    (sub_q),
    .add    (add_q),
    .out_zp (32'(OUT_ZP)),
    .y      (y)
  );

`ifdef FC_ARGMAX_EN
  localparam int CW = $clog2(N_OUT);

  logic signed [7:0] best_y;
  logic [CW-1:0]     best_idx, idx_now, cls_idx_q;
  logic              take_new, cls_valid_q;

  // Strict greater-than keeps the earliest index on ties.
  assign idx_now  = o_idx[CW-1:0];
  assign take_new = (o_idx == 16'd0) || (y > best_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_y      <= '0;
      best_idx    <= '0;
      cls_idx_q   <= '0;
      cls_valid_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      cls_idx_q   <= '0;
      cls_valid_q <= 1'b0;
    end else if (state == S_WRITE) begin
      if (take_new) begin
        best_y   <= y;
        best_idx <= idx_now;
      end
      if (o_idx == O_LAST) begin
        cls_idx_q   <= take_new ? idx_now : best_idx;
        cls_valid_q <= 1'b1;
      end
    end
  end

  assign class_idx   = cls_idx_q;
  assign class_valid = cls_valid_q;
`else
  assign class_idx   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: latency-accurate memory models, write
// scoreboard, reset/abort and start-ignore checks, argmax checks.
module tb_fc_layer_engine;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [15:0]        ram_addr_r, rom_addr_w, ram_addr_w;
  logic               ram_en_r, rom_en_w, rom_en_p, ram_en, ram_wea;
  logic signed [7:0]  ram_data_r, rom_data_w, ram_data_w;
  logic [8:0]         rom_addr_p;
  logic [31:0]        rom_data_p;
  logic [0:0]         class_idx;
  logic               class_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic signed [7:0] act_m [8];
  logic signed [7:0] w_m [16];
  logic [31:0]       p_m [6];
  logic signed [7:0] a_s0 = 0, a_s1 = 0, w_s0 = 0, w_s1 = 0;
  logic [31:0]       p_s0 = 0, p_s1 = 0;

  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fc_layer_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ram_addr_r  (ram_addr_r),
    .ram_en_r    (ram_en_r),
    .ram_data_r  (ram_data_r),
    .rom_addr_w  (rom_addr_w),
    .rom_en_w    (rom_en_w),
    .rom_data_w  (rom_data_w),
    .rom_addr_p  (rom_addr_p),
    .rom_en_p    (rom_en_p),
    .rom_data_p  (rom_data_p),
    .ram_addr_w  (ram_addr_w),
    .ram_data_w  (ram_data_w),
    .ram_en      (ram_en),
    .ram_wea     (ram_wea),
    .class_idx   (class_idx),
    .class_valid (class_valid)
  );

  // Two-stage read pipelines give the RD_LAT=2 memory latency.
  always @(posedge clk) begin : mem_model
    int ai, wi, pi;
    ai = int'(ram_addr_r);
    wi = int'(rom_addr_w) - 21960;
    pi = int'(rom_addr_p) - 168;
    a_s0 <= (ram_en_r && ai < 8) ? act_m[ai] : 8'sd0;
    w_s0 <= (rom_en_w && wi >= 0 && wi < 16) ? w_m[wi] : 8'sd0;
    p_s0 <= (rom_en_p && pi >= 0 && pi < 6) ? p_m[pi] : 32'd0;
    a_s1 <= a_s0;
    w_s1 <= w_s0;
    p_s1 <= p_s0;
  end
  assign ram_data_r = a_s1;
  assign rom_data_w = w_s1;
  assign rom_data_p = p_s1;

  always @(negedge clk) begin
    if (ram_en && ram_wea) wr_q.push_back({ram_addr_w, ram_data_w});
    if (done) done_cnt++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_params(input int o, input logic [31:0] m, input logic [31:0] sub,
                            input logic [31:0] add);
    p_m[3*o]   = m;
    p_m[3*o+1] = sub;
    p_m[3*o+2] = add;
  endtask

  task automatic set_uniform(input logic signed [7:0] x, input logic signed [7:0] w);
    for (int i = 0; i < 8; i++) act_m[i] = x;
    for (int i = 0; i < 16; i++) w_m[i] = w;
  endtask

  task automatic run_fc(input string tag, input logic signed [7:0] y0,
                        input logic signed [7:0] y1, input logic exp_idx, input bit extra);
    int lat;
    int d0;
    logic [23:0] got, want;
    d0 = done_cnt;
    wr_q.delete();
    exp_q.delete();
    exp_q.push_back({16'h8000, y0});
    exp_q.push_back({16'h8001, y1});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && lat < 200) begin
      start = extra && (lat == 4 || lat == 19);
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd48);
`ifdef FC_ARGMAX_EN
    chk({tag, " class_valid"}, 32'(class_valid), 32'd1);
    chk({tag, " class_idx"}, 32'(class_idx), 32'(exp_idx));
`else
    chk({tag, " class_valid"}, 32'(class_valid), 32'd0);
    chk({tag, " class_idx"}, 32'(class_idx), 32'd0);
`endif
    repeat (60) @(posedge clk);
    #1;
    chk({tag, " done count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, " write count"}, 32'(wr_q.size()), 32'd2);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
`ifdef FC_ARGMAX_EN
    chk({tag, " class_idx hold"}, 32'(class_idx), 32'(exp_idx));
`endif
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = wr_q.pop_front();
      chk({tag, " write"}, 32'(got), 32'(want));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int d0;
    for (int i = 0; i < 6; i++) p_m[i] = 32'd0;
    set_uniform(8'sd0, 8'sd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ram_en", 32'({ram_en, ram_wea}), 32'd0);
    chk("reset rd enables", 32'({ram_en_r, rom_en_w, rom_en_p}), 32'd0);
    chk("reset addr_w", 32'(ram_addr_w), 32'd0);
    chk("reset class", 32'({class_valid, class_idx}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_uniform(8'sd1, 8'sd1);
    set_params(0, 32'h8000_0000, 32'd0, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd0);
    run_fc("ones", 8'sd45, 8'sd45, 1'b0, 1'b0);

    set_uniform(8'sd127, 8'sd127);
    run_fc("sat_hi", 8'sd127, 8'sd127, 1'b0, 1'b0);

    set_uniform(-8'sd128, 8'sd127);
    set_params(0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    set_params(1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run_fc("sat_lo", -8'sd128, -8'sd128, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) act_m[i] = (i < 3) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < 8; i++) begin
      w_m[i]   = 8'sd1;
      w_m[8+i] = -8'sd1;
    end
    set_params(0, 32'h8000_0000, 32'd0, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd0);
    run_fc("round", 8'sd43, 8'sd40, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      act_m[i] = 8'(i + 1);
      w_m[i]   = 8'(i - 4);
      w_m[8+i] = 8'(-(i + 1));
    end
    set_params(0, 32'h4000_0000, 32'd4, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd100);
    run_fc("mixed", 8'sd46, -8'sd11, 1'b0, 1'b0);

    set_uniform(8'sd1, 8'sd1);
    set_params(0, 32'h8000_0000, 32'd70, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd10);
    run_fc("argmax", 8'sd10, 8'sd50, 1'b1, 1'b0);

    set_params(0, 32'h8000_0000, 32'd0, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd0);
    run_fc("restart_ignored", 8'sd45, 8'sd45, 1'b0, 1'b1);

    // Abort mid-run before the first write, then confirm a clean rerun.
    wr_q.delete();
    d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (24) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ram_en", 32'({ram_en, ram_wea}), 32'd0);
    chk("abort rd enables", 32'({ram_en_r, rom_en_w, rom_en_p}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort writes", 32'(wr_q.size()), 32'd0);
    chk("abort done", 32'(done_cnt - d0), 32'd0);

    set_params(0, 32'h8000_0000, 32'd70, 32'd0);
    set_params(1, 32'h8000_0000, 32'd0, 32'd10);
    run_fc("after_abort", 8'sd10, 8'sd50, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- N_IN, 8, input activations per output neuron.
- N_OUT, 2, output neurons.
- RD_LAT, 2, cycles from address/enable to valid read data on every memory port.
- IN_BASE, 16'h0000, activation RAM base.
- W_BASE, 16'd21960, weight ROM base.
- P_BASE, 9'd168, parameter ROM base.
- OUT_BASE, 16'h8000, result RAM base.
- OUT_ZP, 41, output zero point.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, sole clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, run request, sampled in IDLE.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle completion pulse.
- ram_addr_r, out, 16, activation read address; ram_en_r, out, 1, read enable; ram_data_r, in, 8, signed activation.
- rom_addr_w, out, 16, weight address; rom_en_w, out, 1, enable; rom_data_w, in, 8, signed weight.
- rom_addr_p, out, 9, parameter address; rom_en_p, out, 1, enable; rom_data_p, in, 32, parameter word.
- ram_addr_w, out, 16, result address; ram_data_w, out, 8, signed result; ram_en, out, 1, enable; ram_wea, out, 1, write strobe.
- class_idx, out, clog2(N_OUT), argmax index; class_valid, out, 1, index valid.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_ACT, LOAD_PAR, MAC, REQ, WRITE, DONE; only an asserted start in IDLE SHALL cause a transition to LOAD_ACT, and start SHALL be ignored in all other states.
REQ-004 LOAD_ACT SHALL read IN_BASE+i for i=0..N_IN-1, one address per cycle, capturing data RD_LAT cycles later, in N_IN+RD_LAT cycles; activations SHALL be loaded once per run.
REQ-005 For each output o, LOAD_PAR SHALL read P_BASE+3o+k for k=0..2 (M unsigned multiplier, SUB, ADD) in 3+RD_LAT cycles.
REQ-006 MAC SHALL stream weights from W_BASE+o*N_IN+i, one signed 8x8 product per cycle, into a 32-bit accumulator cleared at MAC entry; MAC SHALL take N_IN+RD_LAT cycles; the accumulator SHALL wrap modulo 2^32.
REQ-007 REQ SHALL take 3 cycles:
- t = acc - SUB + ADD (32-bit, wrapping).
- p = t (signed) x M (unsigned), exact 64-bit signed product.
- r = (p >>> 32) + p[31] (round half up); y = r + OUT_ZP, saturated to [-128,127].
REQ-008 WRITE SHALL take 1 cycle with ram_en=ram_wea=1, ram_addr_w=OUT_BASE+o and ram_data_w=y; ram_en and ram_wea SHALL be 0 in all other cycles.
REQ-009 After WRITE, the FSM SHALL go to LOAD_PAR for o+1, or to DONE after o=N_OUT-1; DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-010 done SHALL assert exactly (N_IN+RD_LAT)+N_OUT*(N_IN+2*RD_LAT+7) cycles after the start-accept edge (48 at defaults).
REQ-011 Read enables SHALL be high only while the corresponding addresses are being issued or awaited.

Reset
REQ-012 rst_n low SHALL asynchronously force IDLE and clear every output, counter, accumulator and activation register to 0.
REQ-013 A reset mid-run SHALL abort the run with no further writes; the next start SHALL run normally from output 0.

Configuration
REQ-014 With FC_ARGMAX_EN defined:
- The block SHALL track the maximum signed y over the run; ties SHALL resolve to the lowest index.
- class_idx SHALL be set and class_valid pulsed together with done.
- Both outputs SHALL hold until the next start.
REQ-015 Without FC_ARGMAX_EN, class_idx and class_valid SHALL be constant 0 and the comparator logic SHALL not be present.

Structure
REQ-016 Package fc_pkg SHALL hold the FSM state enum, the requant result width constants, and the saturation limits -128/127.
REQ-017 The REQ arithmetic SHALL live in sub-module fc_requant (inputs acc, M, SUB, ADD, OUT_ZP; 3-stage pipeline; output y).

Verification
REQ-018 Defaults, all x=1, w=1, M=2^31, SUB=ADD=0 -> 45 written at 0x8000 and 0x8001; done 48 cycles after start.
REQ-019 x=127, w=127, M=2^31 -> y=127 (saturated high); x=-128, w=127, M=2^32-1 -> y=-128 (saturated low).
REQ-020 Rounding with M=2^31: acc=3 -> y=43; acc=-3 -> y=40.
REQ-021 start pulsed at cycles 5 and 20 of a run -> single run, one done, exactly N_OUT writes; rst_n low at cycle 25 -> no write, busy=0, then a fresh start gives correct results.
REQ-022 FC_ARGMAX_EN, y0=10, y1=50 -> class_idx=1 with class_valid on the done cycle; y0=y1=45 -> class_idx=0; macro undefined -> class_idx=0 and class_valid=0 always.
